// File: rtl/pc_sequencer.sv
// pc_sequencer
// Instruction-sequencing controller for the 8-bit LEG CPU. Owns the program
// counter, drives the registered instruction pROM, and applies jump, call,
// return and halt requests from the decoder in the EXEC state. A small
// return-address stack backs subroutine calls; sticky flags record stack
// overflow and underflow.
//
// Parameters:
//   ROM_LAT     pROM read latency in cycles (1 or 2)
//   STACK_DEPTH number of return-stack entries (2..16)
//   RESET_PC    program counter value after reset
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   run               enables instruction stepping
//   stall             freezes every piece of state while high
//   jump_req          unconditional jump to target (EXEC only)
//   call_req          push pc+1 and jump to target (EXEC only)
//   ret_req           pop return address into pc (EXEC only)
//   halt_req          enter HALT, left only by reset (EXEC only)
//   target[7:0]       jump / call destination
//   rom_addr[7:0]     pROM address, always equal to pc
//   rom_ce            pROM read enable, high in FETCH
//   pc[7:0]           current instruction address
//   ir_valid          pROM output holds the instruction at pc (EXEC)
//   retire            single-cycle pulse as the instruction completes
//   depth[4:0]        number of occupied stack entries
//   stack_ovf         sticky: call attempted with a full stack
//   stack_unf         sticky: return attempted with an empty stack
//   halted            sequencer is in HALT

module pc_sequencer #(
  parameter int          ROM_LAT     = 1,
  parameter int          STACK_DEPTH = 4,
  parameter logic [7:0]  RESET_PC    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       stall,
  input  logic       jump_req,
  input  logic       call_req,
  input  logic       ret_req,
  input  logic       halt_req,
  input  logic [7:0] target,
  output logic [7:0] rom_addr,
  output logic       rom_ce,
  output logic [7:0] pc,
  output logic       ir_valid,
  output logic       retire,
  output logic [4:0] depth,
  output logic       stack_ovf,
  output logic       stack_unf,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  localparam int         IW         = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [4:0] FULL_DEPTH = 5'(STACK_DEPTH);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [4:0] depth_q, depth_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic [7:0] stack_q [STACK_DEPTH];
  logic [7:0] stack_d [STACK_DEPTH];

  logic [7:0]    pc_inc;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;

  // Entry depth_q is the next free slot; the top of stack sits one below it.
  // Push is only performed when not full and pop only when not empty, so the
  // truncated indices always land inside the array.
  assign pc_inc   = pc_q + 8'd1;
  assign push_idx = depth_q[IW-1:0];
  assign pop_idx  = IW'(depth_q - 5'd1);

  // Next-state and datapath update. Nothing moves while stall is high, and
  // the decoder requests are only looked at on a non-stalled EXEC cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;

    if (!stall) begin
      case (state_q)
        S_IDLE: begin
          if (run) state_d = S_FETCH;
        end
        S_FETCH: begin
          state_d = (ROM_LAT == 2) ? S_WAIT : S_EXEC;
        end
        S_WAIT: begin
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
            // The instruction always completes; run only decides whether
            // another fetch follows.
            state_d = run ? S_FETCH : S_IDLE;
            if (ret_req) begin
              if (depth_q != 5'd0) begin
                pc_d    = stack_q[pop_idx];
                depth_d = depth_q - 5'd1;
              end else begin
                unf_d = 1'b1;
                pc_d  = pc_inc;
              end
            end else if (call_req) begin
              if (depth_q != FULL_DEPTH) begin
                stack_d[push_idx] = pc_inc;
                pc_d              = target;
                depth_d           = depth_q + 5'd1;
              end else begin
                ovf_d = 1'b1;
                pc_d  = pc_inc;
              end
            end else if (jump_req) begin
              pc_d = target;
            end else begin
              pc_d = pc_inc;
            end
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      depth_q <= 5'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign pc        = pc_q;
  assign rom_addr  = pc_q;
  assign rom_ce    = (state_q == S_FETCH);
  assign ir_valid  = (state_q == S_EXEC);
  assign retire    = (state_q == S_EXEC) && !stall;
  assign halted    = (state_q == S_HALT);
  assign depth     = depth_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed bench for pc_sequencer. dut_a runs with ROM_LAT=1 and the default
// stack; dut_b runs with ROM_LAT=2 and a non-zero RESET_PC.

module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, stall, jump_req, call_req, ret_req, halt_req;
  logic [7:0] target;
  logic [7:0] rom_addr, pc;
  logic       rom_ce, ir_valid, retire, stack_ovf, stack_unf, halted;
  logic [4:0] depth;

  logic       rst_b, run_b, call_b;
  logic [7:0] target_b;
  logic [7:0] rom_addr_b, pc_b;
  logic       rom_ce_b, ir_valid_b, retire_b, stack_ovf_b, stack_unf_b, halted_b;
  logic [4:0] depth_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ROM_LAT(1), .STACK_DEPTH(4), .RESET_PC(8'h00)) dut_a (
    .clk(clk), .rst(rst), .run(run), .stall(stall),
    .jump_req(jump_req), .call_req(call_req), .ret_req(ret_req), .halt_req(halt_req),
    .target(target), .rom_addr(rom_addr), .rom_ce(rom_ce), .pc(pc),
    .ir_valid(ir_valid), .retire(retire), .depth(depth),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf), .halted(halted)
  );

  pc_sequencer #(.ROM_LAT(2), .STACK_DEPTH(4), .RESET_PC(8'hA0)) dut_b (
    .clk(clk), .rst(rst_b), .run(run_b), .stall(1'b0),
    .jump_req(1'b0), .call_req(call_b), .ret_req(1'b0), .halt_req(1'b0),
    .target(target_b), .rom_addr(rom_addr_b), .rom_ce(rom_ce_b), .pc(pc_b),
    .ir_valid(ir_valid_b), .retire(retire_b), .depth(depth_b),
    .stack_ovf(stack_ovf_b), .stack_unf(stack_unf_b), .halted(halted_b)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; stall = 1'b0;
    jump_req = 1'b0; call_req = 1'b0; ret_req = 1'b0; halt_req = 1'b0;
    target = 8'h00;
    step();
    rst = 1'b0;
  endtask

  // Leaves dut_a in FETCH at pc 0.
  task automatic reset_and_start();
    do_reset();
    run = 1'b1;
    step();
  endtask

  // From FETCH: one ROM_LAT=1 instruction with the given requests, ending
  // in the following FETCH (run held high).
  task automatic do_instr(input logic j, input logic c, input logic r,
                          input logic h, input logic [7:0] t);
    jump_req = j; call_req = c; ret_req = r; halt_req = h; target = t;
    step();
    step();
    jump_req = 1'b0; call_req = 1'b0; ret_req = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 8'h00); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_rom_addr: got %h expected %h", rom_addr, 8'h00); end
    checks++; if (rom_ce !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_ce: got %b expected 0", rom_ce); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ir_valid: got %b expected 0", ir_valid); end
    checks++; if (retire !== 1'b0) begin errors++; $display("[TB] FAIL reset_retire: got %b expected 0", retire); end
    checks++; if (depth !== 5'd0) begin errors++; $display("[TB] FAIL reset_depth: got %0d expected 0", depth); end
    checks++; if (stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got ovf=%b unf=%b expected 0 0", stack_ovf, stack_unf); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
    // IDLE must not fetch while run is low.
    step();
    checks++; if (rom_ce !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_fetch: got %b expected 0", rom_ce); end
  endtask

  task automatic test_sequential();
    logic [7:0] exp_addr [6];
    logic       exp_valid [6];
    exp_addr  = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02};
    exp_valid = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (rom_addr !== exp_addr[i]) begin errors++; $display("[TB] FAIL seq_addr[%0d]: got %h expected %h", i, rom_addr, exp_addr[i]); end
      checks++; if (ir_valid !== exp_valid[i] || retire !== exp_valid[i]) begin errors++; $display("[TB] FAIL seq_valid[%0d]: got ir_valid=%b retire=%b expected %b", i, ir_valid, retire, exp_valid[i]); end
      checks++; if (rom_ce !== ~exp_valid[i]) begin errors++; $display("[TB] FAIL seq_rom_ce[%0d]: got %b expected %b", i, rom_ce, ~exp_valid[i]); end
    end
  endtask

  task automatic test_jump_priority();
    // call and ret together on an empty stack: ret wins and underflows.
    reset_and_start();
    for (int i = 0; i < 5; i++) do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 8'h05) begin errors++; $display("[TB] FAIL prio_start_pc: got %h expected %h", pc, 8'h05); end
    do_instr(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    checks++; if (pc !== 8'h06) begin errors++; $display("[TB] FAIL prio_ret_pc: got %h expected %h", pc, 8'h06); end
    checks++; if (stack_unf !== 1'b1) begin errors++; $display("[TB] FAIL prio_unf: got %b expected 1", stack_unf); end
    checks++; if (depth !== 5'd0) begin errors++; $display("[TB] FAIL prio_no_push: got %0d expected 0", depth); end
    // plain jump from pc 5
    reset_and_start();
    for (int i = 0; i < 5; i++) do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'h40);
    checks++; if (rom_addr !== 8'h40 || rom_ce !== 1'b1) begin errors++; $display("[TB] FAIL jump_addr: got %h ce=%b expected 40 ce=1", rom_addr, rom_ce); end
    checks++; if (stack_unf !== 1'b0) begin errors++; $display("[TB] FAIL unf_cleared_by_rst: got %b expected 0", stack_unf); end
    // call outranks jump
    do_instr(1'b1, 1'b1, 1'b0, 1'b0, 8'h90);
    checks++; if (pc !== 8'h90 || depth !== 5'd1) begin errors++; $display("[TB] FAIL call_over_jump: got pc=%h depth=%0d expected pc=90 depth=1", pc, depth); end
  endtask

  task automatic test_call_ret();
    logic [7:0] exp_ret [4];
    exp_ret = '{8'h31, 8'h21, 8'h11, 8'h01};
    reset_and_start();
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
    do_instr(1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
    checks++; if (pc !== 8'h80 || depth !== 5'd1) begin errors++; $display("[TB] FAIL call_pc: got pc=%h depth=%0d expected pc=80 depth=1", pc, depth); end
    do_instr(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (pc !== 8'h11 || depth !== 5'd0) begin errors++; $display("[TB] FAIL ret_pc: got pc=%h depth=%0d expected pc=11 depth=0", pc, depth); end
    // fill the stack, then overflow
    reset_and_start();
    for (int k = 0; k < 4; k++) begin
      do_instr(1'b0, 1'b1, 1'b0, 1'b0, 8'((k + 1) * 16));
      checks++; if (depth !== 5'(k + 1)) begin errors++; $display("[TB] FAIL nest_depth[%0d]: got %0d expected %0d", k, depth, k + 1); end
    end
    checks++; if (stack_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b expected 0", stack_ovf); end
    do_instr(1'b0, 1'b1, 1'b0, 1'b0, 8'h50);
    checks++; if (stack_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", stack_ovf); end
    checks++; if (depth !== 5'd4 || pc !== 8'h41) begin errors++; $display("[TB] FAIL ovf_state: got depth=%0d pc=%h expected depth=4 pc=41", depth, pc); end
    for (int k = 0; k < 4; k++) begin
      do_instr(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (pc !== exp_ret[k] || depth !== 5'(3 - k)) begin errors++; $display("[TB] FAIL lifo_ret[%0d]: got pc=%h depth=%0d expected pc=%h depth=%0d", k, pc, depth, exp_ret[k], 3 - k); end
    end
    checks++; if (stack_ovf !== 1'b1 || stack_unf !== 1'b0) begin errors++; $display("[TB] FAIL flags_after_rets: got ovf=%b unf=%b expected 1 0", stack_ovf, stack_unf); end
  endtask

  task automatic test_wrap();
    reset_and_start();
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL wrap_seq: got %h expected 00", pc); end
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    do_instr(1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
    checks++; if (pc !== 8'h20 || depth !== 5'd1) begin errors++; $display("[TB] FAIL wrap_call: got pc=%h depth=%0d expected pc=20 depth=1", pc, depth); end
    do_instr(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (pc !== 8'h00 || depth !== 5'd0) begin errors++; $display("[TB] FAIL wrap_ret: got pc=%h depth=%0d expected pc=00 depth=0", pc, depth); end
  endtask

  task automatic test_stall_run();
    reset_and_start();
    jump_req = 1'b1; target = 8'h55;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 8'h00 || retire !== 1'b0 || ir_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold[%0d]: got pc=%h retire=%b ir_valid=%b expected 00 0 1", i, pc, retire, ir_valid); end
    end
    stall = 1'b0;
    #1;
    checks++; if (retire !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_retire: got %b expected 1", retire); end
    step();
    jump_req = 1'b0;
    checks++; if (pc !== 8'h55 || rom_ce !== 1'b1) begin errors++; $display("[TB] FAIL stall_jump: got pc=%h ce=%b expected 55 1", pc, rom_ce); end
    // drop run while fetching: the instruction still completes
    run = 1'b0;
    step();
    checks++; if (retire !== 1'b1) begin errors++; $display("[TB] FAIL run_drop_retire: got %b expected 1", retire); end
    step();
    checks++; if (rom_ce !== 1'b0 || ir_valid !== 1'b0 || pc !== 8'h56) begin errors++; $display("[TB] FAIL run_drop_idle: got ce=%b valid=%b pc=%h expected 0 0 56", rom_ce, ir_valid, pc); end
    step();
    checks++; if (rom_ce !== 1'b0 || pc !== 8'h56) begin errors++; $display("[TB] FAIL idle_stays: got ce=%b pc=%h expected 0 56", rom_ce, pc); end
  endtask

  task automatic test_halt();
    reset_and_start();
    do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    // halt outranks a simultaneous jump
    do_instr(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
    checks++; if (halted !== 1'b1 || rom_ce !== 1'b0 || pc !== 8'h02) begin errors++; $display("[TB] FAIL halt_enter: got halted=%b ce=%b pc=%h expected 1 0 02", halted, rom_ce, pc); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (halted !== 1'b1 || rom_ce !== 1'b0 || ir_valid !== 1'b0 || pc !== 8'h02) begin errors++; $display("[TB] FAIL halt_hold[%0d]: got halted=%b ce=%b valid=%b pc=%h expected 1 0 0 02", i, halted, rom_ce, ir_valid, pc); end
    end
    do_reset();
    checks++; if (halted !== 1'b0 || pc !== 8'h00) begin errors++; $display("[TB] FAIL halt_exit_rst: got halted=%b pc=%h expected 0 00", halted, pc); end
  endtask

  task automatic test_lat2_reset_mid_wait();
    logic [7:0] exp_addr [6];
    logic       exp_valid [6];
    logic       exp_ce [6];
    exp_addr  = '{8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA1};
    exp_valid = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_ce    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rst_b = 1'b1; run_b = 1'b0; call_b = 1'b0; target_b = 8'h00;
    step();
    rst_b = 1'b0;
    checks++; if (pc_b !== 8'hA0) begin errors++; $display("[TB] FAIL lat2_reset_pc: got %h expected a0", pc_b); end
    run_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (rom_addr_b !== exp_addr[i] || ir_valid_b !== exp_valid[i] || rom_ce_b !== exp_ce[i]) begin errors++; $display("[TB] FAIL lat2_seq[%0d]: got addr=%h valid=%b ce=%b expected %h %b %b", i, rom_addr_b, ir_valid_b, rom_ce_b, exp_addr[i], exp_valid[i], exp_ce[i]); end
    end
    step();
    call_b = 1'b1; target_b = 8'h30;
    step();
    step();
    step();
    call_b = 1'b0;
    checks++; if (pc_b !== 8'h30 || depth_b !== 5'd1 || rom_ce_b !== 1'b1) begin errors++; $display("[TB] FAIL lat2_call: got pc=%h depth=%0d ce=%b expected 30 1 1", pc_b, depth_b, rom_ce_b); end
    step();
    checks++; if (rom_ce_b !== 1'b0 || ir_valid_b !== 1'b0) begin errors++; $display("[TB] FAIL lat2_in_wait: got ce=%b valid=%b expected 0 0", rom_ce_b, ir_valid_b); end
    #2 rst_b = 1'b1;
    #1;
    checks++; if (pc_b !== 8'hA0 || rom_addr_b !== 8'hA0 || depth_b !== 5'd0) begin errors++; $display("[TB] FAIL async_rst_pc: got pc=%h addr=%h depth=%0d expected a0 a0 0", pc_b, rom_addr_b, depth_b); end
    checks++; if (rom_ce_b !== 1'b0 || ir_valid_b !== 1'b0 || retire_b !== 1'b0 || halted_b !== 1'b0 || stack_ovf_b !== 1'b0 || stack_unf_b !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_ctl: got ce=%b valid=%b retire=%b halted=%b ovf=%b unf=%b expected all 0", rom_ce_b, ir_valid_b, retire_b, halted_b, stack_ovf_b, stack_unf_b); end
    run_b = 1'b0;
    step();
    rst_b = 1'b0;
    step();
    checks++; if (rom_ce_b !== 1'b0 || pc_b !== 8'hA0) begin errors++; $display("[TB] FAIL lat2_idle_after_rst: got ce=%b pc=%h expected 0 a0", rom_ce_b, pc_b); end
  endtask

  initial begin
    rst_b = 1'b1; run_b = 1'b0; call_b = 1'b0; target_b = 8'h00;
    test_reset();
    test_sequential();
    test_jump_priority();
    test_call_ret();
    test_wrap();
    test_stall_run();
    test_halt();
    test_lat2_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-sequencing controller for the 8-bit LEG CPU. Owns the program counter and drives the synchronous instruction pROM. Runs a fetch/wait/execute state machine and applies jump, call, return and halt requests from the decoder. A return-address stack of `STACK_DEPTH` entries supports subroutines, and sticky flags report stack overflow and underflow.

## Interface
Parameters:
- `ROM_LAT`, 1 — pROM read latency in cycles; legal values 1..2.
- `STACK_DEPTH`, 4 — number of return-stack entries; legal values 2..16.
- `RESET_PC`, 8'h00 — PC value loaded on reset.

Ports:
- `clk`  in  1 — single clock. All state updates on the rising edge.
- `rst`  in  1 — reset. Asynchronous, active-high.
- `run`  in  1 — enables instruction stepping.
- `stall`  in  1 — freezes all state while high.
- `jump_req`  in  1 — unconditional jump. Sampled in EXEC.
- `call_req`  in  1 — subroutine call. Sampled in EXEC.
- `ret_req`  in  1 — return from subroutine. Sampled in EXEC.
- `halt_req`  in  1 — stop the sequencer. Sampled in EXEC.
- `target`  in  8 — jump or call destination.
- `rom_addr`  out  8 — pROM address. Equals `pc`.
- `rom_ce`  out  1 — pROM read enable.
- `pc`  out  8 — current instruction address.
- `ir_valid`  out  1 — pROM output holds the instruction at `pc`.
- `retire`  out  1 — one-cycle pulse when the instruction completes.
- `depth`  out  5 — number of occupied stack entries.
- `stack_ovf`  out  1 — sticky overflow flag.
- `stack_unf`  out  1 — sticky underflow flag.
- `halted`  out  1 — sequencer is in the HALT state.

## Operation
States: IDLE, FETCH, WAIT, EXEC, HALT.

State transitions:
- IDLE → FETCH when `run`=1.
- FETCH → WAIT if `ROM_LAT`=2, otherwise FETCH → EXEC.
- WAIT → EXEC.
- EXEC → HALT if the halt action is taken.
- EXEC → FETCH if `run`=1, otherwise EXEC → IDLE.
- HALT is left only by `rst`.

Combinational outputs:
- `rom_ce`=1 only in FETCH.
- `ir_valid`=1 only in EXEC.
- `retire` = EXEC & ~`stall`.
- `halted` = (state==HALT).

EXEC action, taken when `stall`=0. Priority is halt > ret > call > jump > sequential:
- halt: `pc` unchanged.
- ret, stack not empty: pop the top entry into `pc`; `depth`-1.
- ret, stack empty: set `stack_unf`; `pc`+1.
- call, stack not full: push `pc`+1; `pc`=`target`; `depth`+1.
- call, stack full: set `stack_ovf`; `pc`+1; stack unchanged.
- jump: `pc`=`target`.
- sequential: `pc`+1.

Arithmetic and stall rules:
- All PC arithmetic is modulo 256. 8'hFF+1 = 8'h00, including the value pushed by a call.
- `stall`=1 in any state holds state, `pc`, stack, `depth` and flags.
- Request inputs are ignored outside EXEC and while stalled.
- Deasserting `run` mid-instruction does not abort it. The current instruction completes, then the sequencer enters IDLE.
- Flags clear only on `rst`.

## Timing
Reset values, applied immediately on `rst` (asynchronous), in any state including mid-instruction:
- state=IDLE, `pc`=`RESET_PC`.
- `depth`=0, all stack entries 0.
- `rom_ce`=0, `ir_valid`=0, `retire`=0.
- `stack_ovf`=0, `stack_unf`=0, `halted`=0.

Cycle-level timing:
- Cycles per instruction with no stall: 1+`ROM_LAT`.
- First FETCH occurs the cycle after `run` is sampled high in IDLE.
- pROM is registered. Data for the address presented in FETCH is valid in EXEC.
- New `pc` is visible the cycle after EXEC, on `rom_addr` during the next FETCH.
- `retire` and the EXEC action happen on the same edge.
- Stack push/pop and `depth` update happen on the EXEC edge.
- `depth` ranges 0..`STACK_DEPTH`.

## Test plan
- Sequential fetch: `rst` pulse, `ROM_LAT`=1, `run`=1 → `rom_addr` = 0,0,1,1,2,2; `ir_valid` and `retire` high on every 2nd cycle. With `ROM_LAT`=2, each address is held 3 cycles.
- Jump and priority: EXEC at `pc`=5 with `jump_req`=1, `target`=8'h40 → next `rom_addr`=8'h40. EXEC with `call_req`=1 and `ret_req`=1 on an empty stack → `stack_unf`=1, `pc`=6, no push.
- Call/return and overflow: call from 8'h10 to 8'h80, then ret → `pc`=8'h11, `depth` 1→0. Five nested calls with `STACK_DEPTH`=4 → `stack_ovf`=1 after the 5th; `depth`=4; `pc`=previous+1. Four rets then return the pushed addresses in LIFO order.
- Wrap-around: sequential step at `pc`=8'hFF → `pc`=8'h00. Call at 8'hFF to 8'h20, then ret → `pc`=8'h00.
- Stall and run: `stall`=1 for 3 cycles in EXEC with `jump_req`=1 → `pc` frozen, `retire`=0. Jump taken on the release edge. `run`=0 during FETCH → instruction retires, then IDLE with `rom_ce`=0.
- Halt and reset: `halt_req` in EXEC → `halted`=1, `rom_ce`=0, `pc` constant for 10 cycles despite `run`=1. `rst` asserted mid-WAIT → all outputs at reset values before the next clock edge.
